// File: rtl/pc_seq.sv
// Fetch-stage program counter: selects the next PC from increment, branch,
// jump or exception vectors, with stall, a latched interrupt and a saved XP.
module pc_seq #(
    parameter int               WIDTH     = 32,
    parameter int               OFF_BITS  = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [WIDTH-1:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic [OFF_BITS-1:0] id,
    input  logic [WIDTH-1:0]    jt,
    input  logic [2:0]          pcsel,
    input  logic                irq,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    pc_inc,
    output logic [WIDTH-1:0]    pc_offset,
    output logic [WIDTH-1:0]    xp,
    output logic                supervisor,
    output logic                irq_taken
);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] xp_reg, xp_next;
    logic             irq_pend_reg, irq_pend_next;
    logic             irq_taken_reg, irq_taken_next;

    logic [WIDTH-2:0] id_ext;
    logic [WIDTH-1:0] jump_target;
    logic             illop;

    // Address arithmetic runs on the low WIDTH-1 bits so the supervisor bit never sees a carry.
    assign id_ext      = {{(WIDTH-1-OFF_BITS){id[OFF_BITS-1]}}, id};
    assign pc_inc      = {pc_reg[WIDTH-1], pc_reg[WIDTH-2:0] + (WIDTH-1)'(4)};
    assign pc_offset   = {pc_reg[WIDTH-1], pc_inc[WIDTH-2:0] + (id_ext << 2)};
    assign jump_target = {pc_reg[WIDTH-1] & jt[WIDTH-1], jt[WIDTH-2:2], 2'b00};
    assign illop       = (pcsel >= 3'd3);

    assign pc         = pc_reg;
    assign xp         = xp_reg;
    assign supervisor = pc_reg[WIDTH-1];
    assign irq_taken  = irq_taken_reg;

    always_comb begin
        pc_next        = pc_reg;
        xp_next        = xp_reg;
        irq_pend_next  = irq_pend_reg | irq;
        irq_taken_next = 1'b0;
        if (stall) begin
            // everything holds; only the request latch may still pick up irq
        end else if (illop) begin
            pc_next = ILLOP_VEC;
            xp_next = pc_inc;
        end else if (irq_pend_reg && !supervisor) begin
            pc_next        = XADR_VEC;
            xp_next        = pc_inc;
            irq_pend_next  = 1'b0;
            irq_taken_next = 1'b1;
        end else begin
            case (pcsel)
                3'd0:    pc_next = pc_inc;
                3'd1:    pc_next = pc_offset;
                default: pc_next = jump_target;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg        <= RESET_VEC;
            xp_reg        <= '0;
            irq_pend_reg  <= 1'b0;
            irq_taken_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            xp_reg        <= xp_next;
            irq_pend_reg  <= irq_pend_next;
            irq_taken_reg <= irq_taken_next;
        end
    end

endmodule
